// File: rtl/mcu_el2_pkg.sv
// Shared types for the icache debug access arbiter.
// Request bundle, icache debug packet and sequencer states.
package mcu_el2_pkg;

  typedef struct packed {
    logic        wr;
    logic [16:0] dicawics;
    logic [70:0] wrdata;
  } mcu_el2_ic_dbg_req_pkt_t;

  typedef struct packed {
    logic [70:0] icache_wrdata;
    logic [16:0] icache_dicawics;
    logic        icache_rd_valid;
    logic        icache_wr_valid;
  } mcu_el2_cache_debug_pkt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mcu_el2_ic_dbg_state_t;

endpackage

// File: rtl/mcu_el2_rr_arb2.sv
// Two-way round-robin grant; pointer moves past the
// winner only when the grant is actually accepted.
module mcu_el2_rr_arb2 (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [1:0] req_i,
  input  logic       acc_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  logic ptr_q;

  always_comb begin
    idx_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
    gnt_o = 2'b00;
    if (|req_i) gnt_o[idx_o] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)     ptr_q <= 1'b0;
    else if (acc_i) ptr_q <= ~idx_o;
  end

endmodule

// File: rtl/mcu_el2_ic_dbg_arb.sv
// Icache debug port arbiter: grants one of two requesters,
// issues a one-cycle strobe, waits for read data, responds.
module mcu_el2_ic_dbg_arb
  import mcu_el2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  mcu_el2_ic_dbg_req_pkt_t [1:0] req_pkt,
  output logic [1:0]                    rsp_valid,
  output logic [70:0]                   rsp_data,
  output logic                          rsp_err,
  input  logic                          ic_busy,
  input  logic                          ic_debug_rd_data_valid,
  input  logic [70:0]                   ic_debug_rd_data,
  output mcu_el2_cache_debug_pkt_t      dbg_pkt,
  output logic                          dbg_busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  mcu_el2_ic_dbg_state_t    state_q, state_d;
  mcu_el2_cache_debug_pkt_t dbg_q, dbg_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [1:0]               rsp_valid_q, rsp_valid_d;
  logic [70:0]              rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     wr_q, g_q, busy_q;
  logic [1:0]               gnt;
  logic                     gidx, accept;

  assign accept = (state_q == IDLE) && !ic_busy && |req_valid;

  mcu_el2_rr_arb2 u_arb (
    .clk   (clk),
    .rst_l (rst_l),
    .req_i (req_valid),
    .acc_i (accept),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign req_ready = accept ? gnt : 2'b00;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dbg_d       = dbg_q;
    dbg_d.icache_rd_valid = 1'b0;
    dbg_d.icache_wr_valid = 1'b0;
    rsp_valid_d = 2'b00;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d               = ISSUE;
          dbg_d.icache_wrdata   = req_pkt[gidx].wrdata;
          dbg_d.icache_dicawics = req_pkt[gidx].dicawics;
          dbg_d.icache_rd_valid = ~req_pkt[gidx].wr;
          dbg_d.icache_wr_valid = req_pkt[gidx].wr;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d          = RESP;
          rsp_valid_d[g_q] = 1'b1;
          rsp_data_d       = '0;
          rsp_err_d        = 1'b0;
        end else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // data valid takes priority over an expiring timeout
        if (ic_debug_rd_data_valid) begin
          state_d          = RESP;
          rsp_valid_d[g_q] = 1'b1;
          rsp_data_d       = ic_debug_rd_data;
          rsp_err_d        = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          state_d          = RESP;
          rsp_valid_d[g_q] = 1'b1;
          rsp_data_d       = '0;
          rsp_err_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      dbg_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      wr_q        <= 1'b0;
      g_q         <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dbg_q       <= dbg_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= (state_d != IDLE);
      if (accept) begin
        wr_q <= req_pkt[gidx].wr;
        g_q  <= gidx;
      end
    end
  end

  assign dbg_pkt   = dbg_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_busy  = busy_q;

endmodule
